rbus_demux1ton: RTL and testbench

- Rbus 1-to-N packet demultiplexer: the distribution counterpart of the rbus N-to-1 mux tree.
- Accepts a single rbus stream (stb/sof/72-bit data with 2-bit per-virtual-channel rdy), buffers whole packets in an internal FIFO and routes each packet to one of N rbus outputs.
- Routing uses the destination field of the packet header (sof word); output-side per-VC rdy is honoured.
- Sits at bus fan-out points, e.g. the return path from a shared link to N clients.

---
 rtl/rbus_demux1ton.sv | 210 +++++++++++++++++++++
 tb/tb_rbus_demux1ton.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rbus_demux1ton.sv
// rtl/rbus_demux1ton.sv - rbus 1-to-N packet demultiplexer with shared input packet buffer
//
// Purpose: buffers whole rbus packets arriving on a single input stream and
// routes each one to the output port named in its header destination field,
// honouring the per-VC ready of the selected downstream port.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   i_stb/i_sof/i_data  input word valid, header marker, 72-bit word
//   i_rdy, i_rdyE     per-VC ready to upstream (both VCs share the buffer)
//   o_stb/o_sof/o_data  per-port registered output word valid, header marker, word
//   o_rdy             per-port per-VC ready from downstream
//   o_rdyE            per-port event ready, not used
//   ff_err            sticky protocol / overflow / bad-destination error

module rbus_demux1ton #(
  parameter int N          = 2,
  parameter int DST_LSB    = 56,
  parameter int LEN_LSB    = 60,
  parameter int VC_BIT     = 71,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_stb,
  input  logic                 i_sof,
  input  logic [71:0]          i_data,
  output logic [1:0]           i_rdy,
  output logic [1:0]           i_rdyE,
  output logic [N-1:0]         o_stb,
  output logic [N-1:0]         o_sof,
  output logic [N-1:0][71:0]   o_data,
  input  logic [N-1:0][1:0]    o_rdy,
  input  logic [N-1:0][1:0]    o_rdyE,
  output logic                 ff_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_DROP} state_t;

  // Packet buffer
  logic [71:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_cnt_nxt;
  logic          w_full, w_empty, w_wr, w_pop;
  logic [71:0]   w_head;

  // Input checker
  logic [3:0]    r_in_rem, w_rem_nxt;
  logic          w_in_err;
  logic [CW-1:0] w_used;
  logic [1:0]    r_rdy;

  // Output FSM
  state_t          r_state;
  logic [3:0]      r_dst, r_cnt;
  logic            r_vc, r_first;
  logic [N-1:0]    r_stb, r_sof;
  logic [N-1:0][71:0] r_data;
  logic [3:0]      w_hdr_dst, w_hdr_len;
  logic            w_hdr_vc, w_hdr_ok, w_hdr_rdy, w_cur_rdy, w_drop_go;
  logic            r_err;
  logic            w_unused_rdye;

  assign w_unused_rdye = ^o_rdyE;

  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_wr    = i_stb && !w_full;
  assign w_head  = r_mem[r_rptr];
  assign w_cnt_nxt = r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= w_cnt_nxt;
    end
  end

  // in_rem tracks words still owed by the packet in progress; those words are
  // reserved when deciding whether another full-size packet fits.
  always_comb begin
    w_rem_nxt = r_in_rem;
    w_in_err  = 1'b0;
    if (i_stb) begin
      if (i_sof) begin
        w_in_err  = (r_in_rem != 4'd0);
        w_rem_nxt = i_data[LEN_LSB +: 4];
      end else if (r_in_rem == 4'd0) begin
        w_in_err  = 1'b1;
      end else begin
        w_rem_nxt = r_in_rem - 4'd1;
      end
      if (w_full) w_in_err = 1'b1;
    end
  end

  // Ready is computed from the post-edge occupancy so the registered value
  // already accounts for a header accepted on the same edge.
  assign w_used = CW'(w_cnt_nxt) + CW'(w_rem_nxt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_rem <= '0;
      r_rdy    <= 2'b00;
    end else begin
      r_in_rem <= w_rem_nxt;
      r_rdy    <= (w_used <= CW'(FIFO_DEPTH - 16)) ? 2'b11 : 2'b00;
    end
  end

  assign i_rdy  = r_rdy;
  assign i_rdyE = r_rdy;

  // Destination is read as the full 4-bit field so encodings beyond N are
  // caught and dropped instead of aliasing onto a real port.
  assign w_hdr_dst = (N == 1) ? 4'd0 : w_head[DST_LSB +: 4];
  assign w_hdr_len = w_head[LEN_LSB +: 4];
  assign w_hdr_vc  = w_head[VC_BIT];
  assign w_hdr_ok  = ({1'b0, w_hdr_dst} < 5'(N));

  always_comb begin
    w_hdr_rdy = 1'b0;
    w_cur_rdy = 1'b0;
    for (int p = 0; p < N; p++) begin
      if (w_hdr_dst == 4'(p)) w_hdr_rdy = o_rdy[p][w_hdr_vc];
      if (r_dst == 4'(p))     w_cur_rdy = o_rdy[p][r_vc];
    end
  end

  assign w_pop     = ((r_state == S_SEND) || (r_state == S_DROP)) && !w_empty;
  assign w_drop_go = (r_state == S_IDLE) && !w_empty && !w_hdr_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_dst   <= '0;
      r_vc    <= 1'b0;
      r_cnt   <= '0;
      r_first <= 1'b0;
      r_stb   <= '0;
      r_sof   <= '0;
      r_data  <= '0;
    end else begin
      r_stb  <= '0;
      r_sof  <= '0;
      r_data <= '0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_dst   <= w_hdr_dst;
            r_vc    <= w_hdr_vc;
            r_cnt   <= w_hdr_len;
            r_first <= 1'b1;
            if (!w_hdr_ok)      r_state <= S_DROP;
            else if (w_hdr_rdy) r_state <= S_SEND;
            else                r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_cur_rdy) r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_pop) begin
            for (int p = 0; p < N; p++) begin
              if (r_dst == 4'(p)) begin
                r_stb[p]  <= 1'b1;
                r_sof[p]  <= r_first;
                r_data[p] <= w_head;
              end
            end
            r_first <= 1'b0;
            if (r_cnt == 4'd0) r_state <= S_IDLE;
            else               r_cnt   <= r_cnt - 4'd1;
          end
        end
        S_DROP: begin
          if (w_pop) begin
            if (r_cnt == 4'd0) r_state <= S_IDLE;
            else               r_cnt   <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       r_err <= 1'b0;
    else if (w_in_err || w_drop_go) r_err <= 1'b1;
  end

  assign o_stb  = r_stb;
  assign o_sof  = r_sof;
  assign o_data = r_data;
  assign ff_err = r_err;

endmodule

// File: tb/tb_rbus_demux1ton.sv
// tb/tb_rbus_demux1ton.sv - self-checking bench for rbus_demux1ton (N=4)

module tb_rbus_demux1ton;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                i_stb, i_sof;
  logic [71:0]         i_data;
  logic [1:0]          i_rdy, i_rdyE;
  logic [N-1:0]        o_stb, o_sof;
  logic [N-1:0][71:0]  o_data;
  logic [N-1:0][1:0]   o_rdy, o_rdyE;
  logic                ff_err;

  rbus_demux1ton #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .i_stb(i_stb), .i_sof(i_sof), .i_data(i_data),
    .i_rdy(i_rdy), .i_rdyE(i_rdyE),
    .o_stb(o_stb), .o_sof(o_sof), .o_data(o_data),
    .o_rdy(o_rdy), .o_rdyE(o_rdyE),
    .ff_err(ff_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic        sof;
    logic [71:0] data;
  } exp_t;

  typedef struct {
    int dst;
    int vc;
    int len;
    int gap;
  } vec_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   stb_events = 0;
  int   last_sof_cyc = 0;
  int   last_stb_cyc = 0;
  int   hdr_cyc = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [71:0] rnd72();
    logic [71:0] d;
    d[31:0]  = $urandom;
    d[63:32] = $urandom;
    d[71:64] = 8'($urandom);
    return d;
  endfunction

  function automatic logic [71:0] mk_hdr(input int dst, input int vc, input int len);
    logic [71:0] h;
    h = rnd72();
    h[71]    = vc[0];
    h[63:60] = len[3:0];
    h[59:56] = dst[3:0];
    return h;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sof, input logic [71:0] d);
    i_stb  = 1'b1;
    i_sof  = sof;
    i_data = d;
    step();
    i_stb  = 1'b0;
    i_sof  = 1'b0;
  endtask

  task automatic send_pkt(input int dst, input int vc, input int len, input bit routed, input int gap);
    int t;
    logic [71:0] d;
    t = 0;
    while (i_rdy !== 2'b11 && t < 2000) begin
      step();
      t++;
    end
    chk("rdy_wait_bound", 72'(t < 2000), 72'(1));
    for (int w = 0; w <= len; w++) begin
      d = (w == 0) ? mk_hdr(dst, vc, len) : rnd72();
      if (routed) sbq.push_back('{dst, (w == 0), d});
      drive(w == 0, d);
      if (w == 0) hdr_cyc = cyc;
      repeat (gap) step();
    end
  endtask

  task automatic drain(input int bound);
    int t;
    t = 0;
    while (sbq.size() != 0 && t < bound) begin
      step();
      t++;
    end
    chk("drain_queue_empty", 72'(sbq.size()), 72'(0));
  endtask

  // Output monitor: every strobed word must be the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        for (int p = 0; p < N; p++) begin
          if (o_stb[p]) begin
            stb_events++;
            last_stb_cyc = cyc;
            if (o_sof[p]) last_sof_cyc = cyc;
            if (sbq.size() == 0) begin
              n_total++;
              $display("FAIL unexpected_stb: port %0d data %0h, required no output", p, o_data[p]);
            end else begin
              e = sbq.pop_front();
              chk("out_port", 72'(p), 72'(e.port));
              chk("out_sof", 72'(o_sof[p]), 72'(e.sof));
              chk("out_data", o_data[p], e.data);
            end
          end
        end
      end
    end
  end

  vec_t vt[8];
  int   ev0;
  int   raise_cyc;
  int   t;

  initial begin
    vt[0] = '{0, 0, 0, 0};
    vt[1] = '{1, 1, 15, 0};
    vt[2] = '{3, 0, 5, 1};
    vt[3] = '{2, 1, 1, 0};
    vt[4] = '{0, 1, 7, 2};
    vt[5] = '{3, 1, 0, 0};
    vt[6] = '{1, 0, 3, 0};
    vt[7] = '{2, 0, 15, 1};

    rst    = 1'b0;
    i_stb  = 1'b0;
    i_sof  = 1'b0;
    i_data = '0;
    o_rdy  = {N{2'b11}};
    o_rdyE = '0;
    repeat (3) step();
    chk("reset_o_stb", 72'(o_stb), 72'(0));
    chk("reset_o_sof", 72'(o_sof), 72'(0));
    chk("reset_o_data", 72'(|o_data), 72'(0));
    chk("reset_ff_err", 72'(ff_err), 72'(0));
    rst = 1'b1;
    step();
    chk("post_reset_i_rdy", 72'(i_rdy), 72'(2'b11));
    chk("post_reset_i_rdyE", 72'(i_rdyE), 72'(2'b11));

    // 3-word packet to port 2: latency and back-to-back output
    send_pkt(2, 0, 2, 1, 0);
    drain(50);
    chk("latency_hdr_to_stb", 72'(last_sof_cyc - hdr_cyc), 72'(2));
    chk("burst_consecutive", 72'(last_stb_cyc - last_sof_cyc), 72'(2));
    chk("basic_ff_err", 72'(ff_err), 72'(0));

    // Table of packets, all ports ready
    for (int i = 0; i < 8; i++) send_pkt(vt[i].dst, vt[i].vc, vt[i].len, 1, vt[i].gap);
    drain(300);
    chk("table_ff_err", 72'(ff_err), 72'(0));

    // Target VC not ready: header held until it rises
    o_rdy[1] = 2'b10;
    send_pkt(1, 0, 3, 1, 0);
    ev0 = stb_events;
    repeat (10) step();
    chk("wait_held", 72'(stb_events - ev0), 72'(0));
    o_rdy[1] = 2'b11;
    raise_cyc = cyc;
    t = 0;
    while (stb_events == ev0 && t < 20) begin
      step();
      t++;
    end
    chk("wait_release_latency", 72'(last_sof_cyc - raise_cyc), 72'(2));
    drain(50);

    // Downstream stalled: two full packets fill the buffer and close i_rdy
    o_rdy = '0;
    send_pkt(0, 1, 15, 1, 0);
    chk("bp_rdy_after_first", 72'(i_rdy), 72'(2'b11));
    send_pkt(3, 0, 15, 1, 0);
    chk("bp_rdy_closed", 72'(i_rdy), 72'(2'b00));
    chk("bp_rdyE_closed", 72'(i_rdyE), 72'(2'b00));
    step();
    chk("bp_no_output", 72'(o_stb), 72'(0));
    o_rdy = {N{2'b11}};
    drain(200);
    step();
    chk("bp_rdy_reopen", 72'(i_rdy), 72'(2'b11));
    chk("bp_ff_err", 72'(ff_err), 72'(0));

    // Out-of-range destination: 4 words dropped, error sticky
    send_pkt(5, 0, 3, 0, 0);
    repeat (10) step();
    chk("drop_ff_err", 72'(ff_err), 72'(1));
    send_pkt(3, 1, 2, 1, 0);
    drain(50);
    chk("drop_ff_err_sticky", 72'(ff_err), 72'(1));

    // Asynchronous reset in the middle of a packet
    send_pkt(0, 0, 15, 1, 0);
    chk("mid_send_active", 72'(o_stb), 72'(4'b0001));
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_o_stb", 72'(o_stb), 72'(0));
    chk("async_rst_ff_err", 72'(ff_err), 72'(0));
    sbq.delete();
    step();
    rst = 1'b1;
    step();
    chk("rst_release_i_rdy", 72'(i_rdy), 72'(2'b11));
    ev0 = stb_events;
    repeat (5) step();
    chk("rst_fifo_empty", 72'(stb_events - ev0), 72'(0));
    send_pkt(2, 1, 4, 1, 0);
    drain(50);
    chk("rst_new_pkt_ff_err", 72'(ff_err), 72'(0));

    // sof on the second word of a 4-word packet
    o_rdy = '0;
    drive(1'b1, mk_hdr(0, 0, 3));
    drive(1'b1, mk_hdr(0, 0, 2));
    drive(1'b0, rnd72());
    drive(1'b0, rnd72());
    step();
    chk("sof_mid_packet_err", 72'(ff_err), 72'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
